lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Load/store control stage between the RISC-V single-cycle core's data port and the word-addressed data memory. It turns byte, halfword and word loads/stores into word-aligned memory operations, with read-modify-write for sub-word stores and sign/zero extension for loads. It holds the core with a stall/done handshake, flags misaligned or illegal accesses, and keeps saturating access and error counters.

## Interface

Parameters:
- `CNT_W`, default 16: width of the access and error counters.

Ports:
- `clk` input 1: clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `req` input 1: core requests an access. `we`, `addr`, `wdata` and `funct3` are held stable until `done`.
- `we` input 1: 1 = store, 0 = load.
- `addr` input 32: byte address.
- `wdata` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `funct3` input 3: RISC-V width code. 000 = b, 001 = h, 010 = w, 100 = bu, 101 = hu.
- `rdata` output 32: load result. Valid only while `done` = 1.
- `done` output 1: one-cycle completion pulse.
- `stall` output 1: combinational, `req & ~done`.
- `err` output 1: valid with `done`. 1 = misaligned or illegal access; no memory write occurred.
- `mem_addr` output 32: word address to dmem, `{addr[31:2], 2'b00}`.
- `mem_we` output 1: dmem write enable.
- `mem_wd` output 32: dmem write data.
- `mem_rd` input 32: dmem combinational read data.
- `acc_cnt` output CNT_W: completed non-error accesses, saturating.
- `err_cnt` output CNT_W: error completions, saturating.

## Operation

- FSM states: IDLE, RD, WR, DONE. Reset state is IDLE.
- IDLE with `req` = 1 is classified in the same cycle:
  - Illegal: `funct3` ∈ {011, 110, 111}, or a store with `funct3` ∈ {100, 101}.
  - Misaligned: half access with `addr[0]` = 1, or word access with `addr[1:0]` ≠ 00.
  - Illegal or misaligned → DONE with `err` = 1.
  - Load → RD.
  - `sw` → WR.
  - `sb`/`sh` → RD.
- RD: capture `mem_rd` into the 32-bit `word_q` register.
  - Load → DONE.
  - Store → WR.
- WR: assert `mem_we` = 1. Then → DONE.
  - `sw`: `mem_wd` = `wdata`.
  - `sb`: `word_q` with byte lane `addr[1:0]` replaced by `wdata[7:0]`.
  - `sh`: `word_q` with half lane `addr[1]` replaced by `wdata[15:0]`.
- DONE: `done` = 1, then → IDLE unconditionally.
  - `rdata` = extracted lane of `word_q`. Little-endian: lane 0 = bits [7:0].
  - b/h are sign-extended; bu/hu are zero-extended; w passes through.
  - `rdata` = 0 for stores and for errors.
- Counters increment in DONE: `err_cnt` if `err`, otherwise `acc_cnt`. Both hold at all-ones (saturate).
- Output values outside the conditions above:
  - `mem_we` = 0 outside WR.
  - `mem_wd` = 0 outside WR.
  - `mem_addr` tracks `addr` combinationally in every state.

## Timing

- Reset (takes effect at the next edge, from any state): FSM → IDLE; `word_q`, `acc_cnt`, `err_cnt` → 0.
- Reset mid-operation aborts the access; no partial write follows. `mem_we` is gated by `~reset`, so an asserted `reset` in WR suppresses the write in that cycle.
- While `reset` = 1, outputs are: `done` = 0, `err` = 0, `rdata` = 0, `mem_we` = 0, `stall` = `req`.
- Latency, with cycle 0 = IDLE with `req` sampled:

| Access | `done` asserted in cycle | Stall cycles | Notes |
|---|---|---|---|
| Load | 2 | 2 | |
| `sw` | 2 | 2 | Write committed at end of cycle 1 |
| `sb`/`sh` | 3 | 3 | Read in cycle 1, write at end of cycle 2 |
| Error | 1 | 1 | |

- Back-to-back: the core advances on the edge that ends DONE. The block returns to IDLE, so a new request is accepted in the following cycle; there is one IDLE cycle between accesses.
- `req` = 0 in IDLE: the block stays in IDLE with no memory activity.
- `req` dropping before `done` is a protocol violation. The block completes the access anyway.
- Sub-word RMW is not atomic against other dmem writers; the core is the only writer.

## Test plan

- Preload word 0x60 = 0x11223344. Issue `sb` at addr 0x61, `wdata` = 0x000000CC.
  - Expect `mem_we` high for exactly one cycle, in cycle 2, with `mem_wd` = 0x1122CC44.
  - Expect `done` in cycle 3, `err` = 0, `acc_cnt` = 1.
- Word 0x60 = 0x80FF7F01:
  - `lb` 0x62 → 0xFFFFFFFF.
  - `lbu` 0x62 → 0x000000FF.
  - `lh` 0x62 → 0xFFFF80FF.
  - `lhu` 0x60 → 0x00007F01.
  - `lw` 0x60 → 0x80FF7F01.
  - Each load: `done` in cycle 2, `stall` high in cycles 0–1.
- `sw` 0x64 with `wdata` = 25 (0x19):
  - Expect `mem_we` = 1 in cycle 1 only.
  - A following `lw` 0x64 returns 0x00000019.
- Error cases:
  - `lw` at 0x62, `sh` at 0x61, and `funct3` = 011 each give `done` + `err` in cycle 1, with no `mem_we`.
  - `err_cnt` = 3 after the three; `acc_cnt` unchanged.
- Reset mid-operation: assert `reset` during the RD cycle of an `sb`.
  - Expect no `mem_we` pulse, FSM in IDLE next cycle, counters = 0.
  - Target word unchanged.
- Saturation: with `CNT_W` = 2, run 5 error accesses → `err_cnt` = 3 and holds at 3.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: sub-word load/store sequencing onto word memory with stall/done handshake and counters
module lsu_mem_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             we,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [2:0]       funct3,
  output logic [31:0]      rdata,
  output logic             done,
  output logic             stall,
  output logic             err,
  output logic [31:0]      mem_addr,
  output logic             mem_we,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd,
  output logic [CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t state, nxt;
  logic [31:0] word_q, ext, rmw;
  logic [7:0] lb;
  logic [15:0] lh;
  logic err_q, bad;
  always_comb begin
    bad = funct3 == 3'b011 || funct3[2:1] == 2'b11 || (we && funct3[2]) ||
          (funct3[1:0] == 2'b01 && addr[0]) || (funct3 == 3'b010 && addr[1:0] != 2'b00);
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = !req ? IDLE : bad ? DONE : (we && funct3 == 3'b010) ? WR : RD;
      RD:      nxt = we ? WR : DONE;
      WR:      nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q  <= '0;
      err_q   <= 1'b0;
      acc_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (state == IDLE) err_q <= bad;
      if (state == RD) word_q <= mem_rd;
      if (state == DONE && err_q && !(&err_cnt)) err_cnt <= err_cnt + CNT_W'(1);
      if (state == DONE && !err_q && !(&acc_cnt)) acc_cnt <= acc_cnt + CNT_W'(1);
    end
  end
  // lane extraction for loads and lane merge for sub-word stores, both from word_q
  always_comb begin
    lb     = word_q[{addr[1:0], 3'b000} +: 8];
    lh     = addr[1] ? word_q[31:16] : word_q[15:0];
    ext    = funct3 == 3'b000 ? {{24{lb[7]}}, lb} :
             funct3 == 3'b001 ? {{16{lh[15]}}, lh} :
             funct3 == 3'b100 ? {24'b0, lb} :
             funct3 == 3'b101 ? {16'b0, lh} : word_q;
    rmw    = funct3 == 3'b010 ? wdata :
             funct3[0] ? (word_q & ~(32'hFFFF << {addr[1], 4'b0000})) | ({16'b0, wdata[15:0]} << {addr[1], 4'b0000}) :
                         (word_q & ~(32'hFF << {addr[1:0], 3'b000})) | ({24'b0, wdata[7:0]} << {addr[1:0], 3'b000});
    done     = state == DONE && !reset;
    err      = done && err_q;
    rdata    = (done && !err_q && !we) ? ext : 32'b0;
    mem_we   = state == WR && !reset;
    mem_wd   = state == WR ? rmw : 32'b0;
    stall    = req && !done;
    mem_addr = {addr[31:2], 2'b00};
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: random and directed accesses checked each cycle against a transaction-level model
module tb_lsu_mem_ctrl;
  logic clk = 1'b0, reset, req, we;
  logic [31:0] addr, wdata;
  logic [2:0] funct3;
  logic [31:0] rdata, mem_addr, mem_wd, mem_rd;
  logic done, stall, err, mem_we;
  logic [15:0] acc_cnt, err_cnt;
  logic [31:0] s_rdata, s_mem_addr, s_mem_wd;
  logic s_done, s_stall, s_err, s_mem_we;
  logic [1:0] s_acc_cnt, s_err_cnt;
  logic [31:0] dmem [64];
  logic [31:0] ref_mem [64];
  int checks = 0, errors = 0, acc_n = 0, err_n = 0;
  bit chk = 0;
  logic e_stall, e_done, e_err, e_we;
  logic [31:0] e_wd, e_rd;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata), .funct3(funct3),
    .rdata(rdata), .done(done), .stall(stall), .err(err), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wd(mem_wd), .mem_rd(mem_rd), .acc_cnt(acc_cnt), .err_cnt(err_cnt));

  lsu_mem_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata), .funct3(funct3),
    .rdata(s_rdata), .done(s_done), .stall(s_stall), .err(s_err), .mem_addr(s_mem_addr), .mem_we(s_mem_we),
    .mem_wd(s_mem_wd), .mem_rd(mem_rd), .acc_cnt(s_acc_cnt), .err_cnt(s_err_cnt));

  assign mem_rd = dmem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) dmem[mem_addr[7:2]] <= mem_wd;

  function automatic int sat(input int n, input int m);
    return n > m ? m : n;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) if (chk) begin
    check("stall", 32'(stall), 32'(e_stall));
    check("done", 32'(done), 32'(e_done));
    check("err", 32'(err), 32'(e_err));
    check("rdata", rdata, e_rd);
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_wd", mem_wd, e_wd);
    check("mem_addr", mem_addr, {addr[31:2], 2'b00});
    check("acc_cnt", 32'(acc_cnt), 32'(sat(acc_n, 65535)));
    check("err_cnt", 32'(err_cnt), 32'(sat(err_n, 65535)));
    check("sat_acc_cnt", 32'(s_acc_cnt), 32'(sat(acc_n, 3)));
    check("sat_err_cnt", 32'(s_err_cnt), 32'(sat(err_n, 3)));
  end

  task automatic setexp(input logic s, input logic d, input logic e, input logic w,
                        input logic [31:0] wd, input logic [31:0] rd);
    e_stall = s; e_done = d; e_err = e; e_we = w; e_wd = wd; e_rd = rd;
  endtask

  task automatic idle();
    req = 0; we = 1'($urandom); addr = $urandom & 32'hFF; wdata = $urandom; funct3 = 3'($urandom);
    setexp(0, 0, 0, 0, 0, 0);
    @(negedge clk); @(posedge clk); #1;
  endtask

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                        input bit lit_en = 0, input logic [31:0] lit = 0);
    logic [31:0] old, nw, rd;
    bit bad;
    int lat, wc, b, h;
    old = ref_mem[a[7:2]];
    bad = f == 3 || f >= 6 || (w && f >= 4) || ((f == 1 || f == 5) && a[0]) || (f == 2 && a[1:0] != 0);
    lat = bad ? 1 : (w && f != 2) ? 3 : 2;
    wc = (bad || !w) ? -1 : (f == 2) ? 1 : 2;
    nw = old;
    if (f == 2) nw = d;
    else if (f == 1) nw[16*a[1] +: 16] = d[15:0];
    else nw[8*a[1:0] +: 8] = d[7:0];
    b = int'((old >> (8*a[1:0])) & 32'hFF);
    h = int'((old >> (16*a[1])) & 32'hFFFF);
    rd = f == 0 ? 32'(b > 127 ? b - 256 : b) : f == 1 ? 32'(h > 32767 ? h - 65536 : h) :
         f == 4 ? 32'(b) : f == 5 ? 32'(h) : old;
    if (bad || w) rd = 0;
    for (int c = 0; c <= lat; c++) begin
      req = 1; we = w; addr = a; wdata = d; funct3 = f;
      setexp(c < lat, c == lat, c == lat && bad, c == wc, c == wc ? nw : 0, c == lat ? rd : 0);
      chk = 1;
      @(negedge clk);
      if (lit_en && c == (w ? wc : lat)) check("literal", w ? mem_wd : rdata, lit);
      @(posedge clk); #1;
    end
    if (wc >= 0) ref_mem[a[7:2]] = nw;
    if (bad) err_n++; else acc_n++;
    idle();
  endtask

  task automatic poke(input int idx, input logic [31:0] v);
    dmem[idx] = v; ref_mem[idx] = v;
  endtask

  initial begin
    reset = 1; req = 0; we = 0; addr = 0; wdata = 0; funct3 = 0;
    for (int i = 0; i < 64; i++) poke(i, $urandom);
    setexp(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk = 1;
    @(negedge clk); @(posedge clk); #1;
    reset = 0;
    idle();

    poke(24, 32'h11223344);
    access(1, 32'h61, 32'hCC, 3'b000, 1, 32'h1122CC44);
    check("acc_after_sb", 32'(acc_cnt), 32'd1);
    poke(24, 32'h80FF7F01);
    access(0, 32'h62, 0, 3'b000, 1, 32'hFFFFFFFF);
    access(0, 32'h62, 0, 3'b100, 1, 32'h000000FF);
    access(0, 32'h62, 0, 3'b001, 1, 32'hFFFF80FF);
    access(0, 32'h60, 0, 3'b101, 1, 32'h00007F01);
    access(0, 32'h60, 0, 3'b010, 1, 32'h80FF7F01);
    access(1, 32'h64, 32'd25, 3'b010, 1, 32'h00000019);
    access(0, 32'h64, 0, 3'b010, 1, 32'h00000019);
    access(0, 32'h62, 0, 3'b010);
    access(1, 32'h61, 32'h1234, 3'b001);
    access(0, 32'h60, 0, 3'b011);
    check("err_triplet", 32'(err_cnt), 32'd3);
    check("acc_unchanged", 32'(acc_cnt), 32'd8);

    // reset lands on the RD cycle of a byte store
    req = 1; we = 1; addr = 32'h61; wdata = 32'h55; funct3 = 3'b000;
    setexp(1, 0, 0, 0, 0, 0);
    @(negedge clk); @(posedge clk); #1;
    reset = 1;
    @(negedge clk); @(posedge clk); #1;
    reset = 0; acc_n = 0; err_n = 0;
    idle();
    check("rmw_aborted", dmem[24], 32'h80FF7F01);
    check("reset_cnt", 32'(acc_cnt), 32'd0);

    for (int i = 0; i < 5; i++) access(0, 32'h40, 0, 3'b111);
    check("sat_hold", 32'(s_err_cnt), 32'd3);
    check("wide_err", 32'(err_cnt), 32'd5);

    for (int i = 0; i < 300; i++)
      access(1'($urandom), $urandom & 32'hFF, $urandom, 3'($urandom));

    chk = 0;
    for (int i = 0; i < 64; i++) check("mem_image", dmem[i], ref_mem[i]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
